// File: rtl/aes_roundkey_store_192_pkg.sv
// ---------------------------------------------------------------------------
// aes192_pkg
// Shared constants and types for the AES-192 round-key store.
//   NUM_RK       : number of round-key slots (initial key + 12 expanded)
//   RK_W         : width of one round key
//   KEY192_W     : width of the AES-192 cipher key
//   FILL_TIMEOUT : cycles after start before an incomplete fill is abandoned
//   state_t      : store FSM state
// ---------------------------------------------------------------------------
package aes192_pkg;

  localparam int NUM_RK       = 13;
  localparam int RK_W         = 128;
  localparam int KEY192_W     = 192;
  localparam int FILL_TIMEOUT = 20;

  localparam int IDX_W  = 4;
  localparam int WDOG_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  // Upstream round indices 1..NUM_RK-1 are writable; slot 0 is only ever
  // loaded from the cipher key itself.
  function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (idx <= IDX_W'(NUM_RK - 1));
  endfunction

endpackage

// File: rtl/aes_roundkey_store_192_if.sv
// ---------------------------------------------------------------------------
// aes_roundkey_store_192_if
// Bundles the key-load, round-key stream and read port of the store.
//   master : key-schedule / cipher side (drives start, key, stream, reads)
//   slave  : the round-key store
// ---------------------------------------------------------------------------
interface aes_roundkey_store_192_if;
  import aes192_pkg::*;

  logic                start;
  logic [KEY192_W-1:0] key192;
  logic [RK_W-1:0]     skey_in;
  logic                skey_valid;
  logic [IDX_W-1:0]    skey_idx;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_addr;
  logic [RK_W-1:0]     rd_data;
  logic                rd_valid;
  logic                rd_miss;
  logic                keys_ready;
  logic                fill_err;

  modport master (
    output start, key192, skey_in, skey_valid, skey_idx, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_miss, keys_ready, fill_err
  );

  modport slave (
    input  start, key192, skey_in, skey_valid, skey_idx, rd_en, rd_addr,
    output rd_data, rd_valid, rd_miss, keys_ready, fill_err
  );

endinterface

// File: rtl/aes_roundkey_store_192_regfile.sv
// ---------------------------------------------------------------------------
// aes_rk_regfile
// 13 x 128-bit round-key storage, one write port, one registered read port.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write slot
//   i_wdata : write data
//   i_re    : read enable; o_rdata updates on the following edge
//   i_raddr : read slot
//   o_rdata : raw slot contents (old value on a same-cycle write)
// ---------------------------------------------------------------------------
module aes_rk_regfile
  import aes192_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [RK_W-1:0]  i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [RK_W-1:0]  o_rdata
);

  logic [RK_W-1:0] r_mem [NUM_RK];
  logic [RK_W-1:0] r_q;

  // NOTE: the array has no reset on purpose -- it maps onto plain flops or
  // RAM; the owner's written-mask decides whether a slot's data is valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read below see the pre-write
    // contents, giving read-old-value behaviour on a same-slot collision.
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/aes_roundkey_store_192.sv
// ---------------------------------------------------------------------------
// aes_roundkey_store_192
// Captures the 13 AES-192 round keys (slot 0 from the cipher key, slots 1..12
// streamed from the expansion stage) and serves them on a 1-cycle read port.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of aes_roundkey_store_192_if
//           start/key192          load slot 0 and begin a fill
//           skey_in/valid/idx     streamed round keys (accepted only in FILL)
//           rd_en/rd_addr         read request
//           rd_data/valid/miss    read result, one cycle later
//           keys_ready            all slots written, store locked
//           fill_err              sticky: bad index or fill timeout
// ---------------------------------------------------------------------------
module aes_roundkey_store_192
  import aes192_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  aes_roundkey_store_192_if.slave bus
);

  state_t              r_state;
  logic [NUM_RK-1:0]   r_mask;
  logic [WDOG_W-1:0]   r_wdog;
  logic                r_keys_ready;
  logic                r_fill_err;
  logic                r_rd_valid;
  logic                r_rd_miss;
  logic                r_rd_hit;

  logic                w_idx_ok;
  logic                w_fill_wr;
  logic                w_we;
  logic [IDX_W-1:0]    w_waddr;
  logic [RK_W-1:0]     w_wdata;
  logic [RK_W-1:0]     w_rdq;
  logic [NUM_RK-1:0]   w_mask_next;
  logic                w_rd_hit;

  assign w_idx_ok  = idx_legal(bus.skey_idx);
  // start wins over a stream beat arriving in the same cycle.
  assign w_fill_wr = (r_state == FILL) && bus.skey_valid && w_idx_ok && !bus.start;

  // Single write port shared by the key load (slot 0) and the stream.
  assign w_we    = !reset && (bus.start || w_fill_wr);
  assign w_waddr = bus.start ? '0 : bus.skey_idx;
  assign w_wdata = bus.start ? bus.key192[KEY192_W-1 -: RK_W] : bus.skey_in;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_mask_next = r_mask;
    if (w_fill_wr) w_mask_next = r_mask | (NUM_RK'(1) << bus.skey_idx);
  end

  // Shifting past bit 12 yields zero, so out-of-range addresses miss.
  assign w_rd_hit = |(r_mask & (NUM_RK'(1) << bus.rd_addr));

  aes_rk_regfile u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (bus.rd_en),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_rdq)
  );

  // Store FSM, written-mask and fill watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_wdog       <= '0;
      r_keys_ready <= 1'b0;
      r_fill_err   <= 1'b0;
    end else if (bus.start) begin
      r_state      <= FILL;
      r_mask       <= NUM_RK'(1);
      // The start cycle counts as the first cycle of the timeout window, so
      // an incomplete fill is abandoned exactly FILL_TIMEOUT cycles after it.
      r_wdog       <= WDOG_W'(1);
      r_keys_ready <= 1'b0;
      r_fill_err   <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_mask <= w_mask_next;
          if (bus.skey_valid && !w_idx_ok) r_fill_err <= 1'b1;
          if (&w_mask_next) begin
            r_state      <= READY;
            r_keys_ready <= 1'b1;
          end else if (r_wdog == WDOG_W'(FILL_TIMEOUT - 1)) begin
            r_state    <= IDLE;
            r_fill_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read qualification uses the mask as it stands in the request cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_miss  <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_rd_miss  <= bus.rd_en && !w_rd_hit;
      r_rd_hit   <= bus.rd_en && w_rd_hit;
    end
  end

  // Unwritten slots hold stale or unknown data; only hits expose it.
  assign bus.rd_data    = r_rd_hit ? w_rdq : '0;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_miss    = r_rd_miss;
  assign bus.keys_ready = r_keys_ready;
  assign bus.fill_err   = r_fill_err;

endmodule

// File: doc/aes_roundkey_store_192.md
AES_ROUNDKEY_STORE_192 -- requirements
Module: aes_roundkey_store_192

Interface
REQ-001 The block SHALL use: clk  in  1  clock; all state updates on its rising edge.
REQ-002 The block SHALL use: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have: start  in  1  one-cycle pulse, same cycle as the key-expansion start.
REQ-004 The block SHALL have: key192  in  192  cipher key, sampled only on start.
REQ-005 The block SHALL have: skey_in  in  128  streamed round key from the expansion stage.
REQ-006 The block SHALL have: skey_valid  in  1  skey_in and skey_idx are valid this cycle.
REQ-007 The block SHALL have: skey_idx  in  4  round index of skey_in; legal range 1..12.
REQ-008 The block SHALL have: rd_en  in  1  read request.
REQ-009 The block SHALL have: rd_addr  in  4  round index to read; legal range 0..12.
REQ-010 The block SHALL have: rd_data  out  128  round key read result.
REQ-011 The block SHALL have: rd_valid  out  1  rd_data valid; one cycle per accepted rd_en.
REQ-012 The block SHALL have: rd_miss  out  1  qualifies rd_valid; requested slot not yet written, or rd_addr > 12.
REQ-013 The block SHALL have: keys_ready  out  1  all 13 round keys held; the store is locked.
REQ-014 The block SHALL have: fill_err  out  1  sticky error flag; cleared only by start or reset.

Function
REQ-015 The store SHALL hold 13 slots of 128 bits, indices 0..12, plus a 13-bit written-mask.
REQ-016 The FSM SHALL have the states IDLE, FILL and READY.
REQ-017 When start is high in any state, slot 0 SHALL be loaded with key192[191:64], mask SHALL become 13'h0001, and the FSM SHALL go to FILL; keys_ready and fill_err SHALL clear on the next edge.
REQ-018 In FILL, skey_valid with skey_idx in 1..12 SHALL write skey_in to that slot and set its mask bit; a repeated index SHALL overwrite the slot.
REQ-019 In FILL, skey_valid with skey_idx equal to 0 or above 12 SHALL leave the slots unchanged, set fill_err, and keep the FSM in FILL.
REQ-020 The FSM SHALL go FILL -> READY on the edge after the mask becomes all ones, counting a write made in that same cycle; keys_ready SHALL be high exactly in READY.
REQ-021 A 5-bit watchdog SHALL count cycles in FILL; when it reaches 20 with the mask incomplete, the FSM SHALL go to IDLE, set fill_err, and keep the mask bits already written.
REQ-022 skey_valid SHALL be ignored in IDLE and READY; writes are never accepted outside FILL.
REQ-023 If start and skey_valid are high in the same cycle, start SHALL win and skey_in SHALL be dropped.
REQ-024 Reads SHALL be accepted in every state with latency 1: rd_en at cycle N gives rd_valid at N+1, carrying the slot contents as they were at N.
REQ-025 If the mask bit of the read slot is clear, or rd_addr > 12, the read SHALL return rd_data=0 and rd_miss=1.
REQ-026 A read of slot k SHALL return the old value when a write to slot k occurs in the same cycle; no write-through.
REQ-027 Back-to-back rd_en on every cycle SHALL be sustained with no bubbles.

Reset
REQ-028 Reset SHALL set the FSM to IDLE and clear the mask and watchdog to 0.
REQ-029 Reset SHALL drive rd_valid=0, rd_miss=0, rd_data=0, keys_ready=0 and fill_err=0.
REQ-030 Slot contents need not reset; the mask alone SHALL gate read data.
REQ-031 Reset SHALL take priority over start and over a fill in progress.

Structure
REQ-032 A shared package aes192_pkg SHALL hold: NUM_RK=13, RK_W=128, KEY192_W=192, FILL_TIMEOUT=20, and the FSM state enum.
REQ-033 The 13x128 storage with its synchronous read port SHALL be one sub-module, aes_rk_regfile; the FSM, mask and watchdog SHALL stay in the top level.

Verification
REQ-034 Key 8e73b0f7da0e6452c810f32b809079e5 62f8ead2522c6b7b, start, then 12 upstream keys on consecutive cycles -> keys_ready high 13 cycles after start; read of addr 0 returns 8e73b0f7da0e6452c810f32b809079e5; read of addr 12 returns e98ba06f448c773c8ecc720401002202.
REQ-035 Read of addr 5 before its write, then read of addr 13 -> both give rd_valid=1, rd_miss=1, rd_data=0.
REQ-036 skey_idx=0 during FILL, then the remaining valid keys -> fill_err=1 and keys_ready=1; slot 0 still holds key192[191:64].
REQ-037 Stream stops after idx 6 -> 20 cycles after start the FSM is in IDLE with fill_err=1 and keys_ready=0; reads of 0..6 hit, reads of 7..12 miss.
REQ-038 start pulsed in READY with a new key -> keys_ready drops the next cycle, slots 1..12 miss, and slot 0 holds the new key.
REQ-039 Reset asserted mid-FILL -> all outputs 0 the next cycle and every read misses.
